// File: rtl/prescaler_pkg.sv
// Shared constants and helpers for the multi-channel tick prescaler.
package prescaler_pkg;

    localparam int DEF_NCH     = 4;
    localparam int DEF_CW      = 16;
    localparam int DEF_DIV_VAL = 20;

    // Index width for a channel select; never narrower than one bit.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/prescaler_channel.sv
// One prescaler channel: period counter, active divisor, shadow divisor and tick.
module prescaler_channel
    import prescaler_pkg::*;
#(
    parameter int CW      = DEF_CW,
    parameter int DEF_DIV = DEF_DIV_VAL
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          sync_clr,
    input  logic          wr,
    input  logic [CW-1:0] wr_val,
    output logic          tick,
    output logic          busy
);

    logic [CW-1:0] cnt;
    logic [CW-1:0] div;
    logic [CW-1:0] shadow;
    logic          wrap;

    // Divisors 0 and 1 both mean "every cycle"; this also keeps div-1 from underflowing.
    assign wrap = (div <= CW'(1)) || (cnt == div - CW'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            div    <= CW'(DEF_DIV);
            shadow <= '0;
            tick   <= 1'b0;
            busy   <= 1'b0;
        end else begin
            if (sync_clr) begin
                cnt  <= '0;
                tick <= 1'b0;
                if (busy) begin
                    div  <= shadow;
                    busy <= 1'b0;
                end
            end else if (en) begin
                if (wrap) begin
                    tick <= 1'b1;
                    cnt  <= '0;
                    if (busy) begin
                        div  <= shadow;
                        busy <= 1'b0;
                    end
                end else begin
                    tick <= 1'b0;
                    cnt  <= cnt + CW'(1);
                end
            end else begin
                // A stalled channel takes its new divisor at once and restarts the period.
                tick <= 1'b0;
                if (busy) begin
                    div  <= shadow;
                    busy <= 1'b0;
                    cnt  <= '0;
                end
            end
            // wr is only asserted while busy is low, so it cannot meet an apply.
            if (wr) begin
                shadow <= wr_val;
                busy   <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/multi_tick_prescaler.sv
// N-channel programmable tick generator with a valid/ready divisor write port.
module multi_tick_prescaler
    import prescaler_pkg::*;
#(
    parameter int NCH     = DEF_NCH,
    parameter int CW      = DEF_CW,
    parameter int DEF_DIV = DEF_DIV_VAL,
    localparam int CHW    = clog2_min1(NCH)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [NCH-1:0] en,
    input  logic           sync_clr,
    input  logic           div_valid,
    input  logic [CHW-1:0] div_ch,
    input  logic [CW-1:0]  div_val,
    output logic           div_ready,
    output logic [NCH-1:0] tick,
    output logic [NCH-1:0] busy
);

    localparam int NPAD = 1 << CHW;

    logic [NPAD-1:0] busy_pad;
    logic            in_range;
    logic            accept;

    // Handshake: a write transfers on a clock edge where div_valid and div_ready
    // are both high; the requester holds div_ch/div_val stable until then.
    // div_ready depends only on registered busy and the request's channel.
    assign busy_pad  = NPAD'(busy);
    assign in_range  = ({1'b0, div_ch} < (CHW+1)'(NCH));
    assign div_ready = in_range & ~busy_pad[div_ch];
    assign accept    = div_valid & div_ready;

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        prescaler_channel #(
            .CW      (CW),
            .DEF_DIV (DEF_DIV)
        ) u_ch (
            .clk      (clk),
            .rst      (rst),
            .en       (en[i]),
            .sync_clr (sync_clr),
            .wr       (accept && (div_ch == CHW'(i))),
            .wr_val   (div_val),
            .tick     (tick[i]),
            .busy     (busy[i])
        );
    end

endmodule

// File: tb/tb_multi_tick_prescaler.sv
// Directed bench for multi_tick_prescaler (NCH=4, CW=16, DEF_DIV=20).
module tb_multi_tick_prescaler;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  en;
    logic        sync_clr;
    logic        div_valid;
    logic [1:0]  div_ch;
    logic [15:0] div_val;
    logic        div_ready;
    logic [3:0]  tick;
    logic [3:0]  busy;

    int          total = 0;
    int          bad   = 0;
    logic [3:0]  exp_t;
    logic [31:0] exp_q[$];

    multi_tick_prescaler #(.NCH(4), .CW(16), .DEF_DIV(20)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .sync_clr  (sync_clr),
        .div_valid (div_valid),
        .div_ch    (div_ch),
        .div_val   (div_val),
        .div_ready (div_ready),
        .tick      (tick),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int c, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, c, obs, exp);
        end
    endtask

    // Holds reset for two edges; the next posedge after return is cycle 1.
    task automatic do_reset();
        rst       = 1'b1;
        en        = 4'b1111;
        sync_clr  = 1'b0;
        div_valid = 1'b0;
        div_ch    = 2'd0;
        div_val   = 16'd0;
        repeat (2) step();
        rst = 1'b0;
    endtask

    initial begin
        // Default divisor, ch1 rewrite to 5 at cycle 7, ch2 paused for cycles 10-14.
        do_reset();
        chk("rst_tick", 0, 32'(tick), 32'h0);
        chk("rst_busy", 0, 32'(busy), 32'h0);
        chk("rst_ready", 0, 32'(div_ready), 32'h1);
        for (int c = 1; c <= 45; c++) begin
            en        = (c >= 10 && c <= 14) ? 4'b1011 : 4'b1111;
            div_valid = (c == 7);
            div_ch    = 2'd1;
            div_val   = 16'd5;
            step();
            exp_t[0] = (c % 20 == 0);
            exp_t[1] = (c >= 20) && (c % 5 == 0);
            exp_t[2] = (c >= 25) && ((c - 25) % 20 == 0);
            exp_t[3] = (c % 20 == 0);
            chk("a_tick", c, 32'(tick), 32'(exp_t));
            chk("a_busy", c, 32'(busy), (c >= 7 && c < 20) ? 32'h2 : 32'h0);
        end

        // Second ch1 write stalls while busy, accepted the cycle after the apply.
        do_reset();
        exp_q = '{32'd20, 32'd25, 32'd32, 32'd39};
        for (int c = 1; c <= 40; c++) begin
            en        = 4'b1111;
            div_valid = (c >= 7 && c <= 21);
            div_ch    = 2'd1;
            div_val   = (c == 7) ? 16'd5 : 16'd7;
            #1;
            if (c >= 7 && c <= 21)
                chk("b_ready", c, 32'(div_ready), 32'(c == 7 || c == 21));
            @(posedge clk);
            #1;
            exp_t[0] = (c % 20 == 0);
            exp_t[1] = 1'b0;
            if (exp_q.size() > 0 && exp_q[0] == 32'(c)) begin
                exp_t[1] = 1'b1;
                void'(exp_q.pop_front());
            end
            exp_t[2] = (c % 20 == 0);
            exp_t[3] = (c % 20 == 0);
            chk("b_tick", c, 32'(tick), 32'(exp_t));
            chk("b_busy", c, 32'(busy),
                ((c >= 7 && c < 20) || (c >= 21 && c < 25)) ? 32'h2 : 32'h0);
        end
        chk("b_queue_empty", 40, 32'(exp_q.size()), 32'h0);

        // sync_clr at cycle 13 applies the pending ch0 divisor and re-phases all channels.
        do_reset();
        for (int c = 1; c <= 36; c++) begin
            en        = 4'b1111;
            div_valid = (c == 5);
            div_ch    = 2'd0;
            div_val   = 16'd3;
            sync_clr  = (c == 13);
            step();
            exp_t[0] = (c >= 16) && ((c - 16) % 3 == 0);
            exp_t[1] = (c == 33);
            exp_t[2] = (c == 33);
            exp_t[3] = (c == 33);
            chk("c_tick", c, 32'(tick), 32'(exp_t));
            chk("c_busy", c, 32'(busy), (c >= 5 && c < 13) ? 32'h1 : 32'h0);
        end
        sync_clr = 1'b0;

        // div=1 on ch2, div=0 on ch3, then reset with a ch0 write pending.
        do_reset();
        for (int c = 1; c <= 10; c++) begin
            en        = (c == 8) ? 4'b0111 : 4'b1111;
            div_valid = (c == 1) || (c == 2) || (c == 10);
            div_ch    = (c == 1) ? 2'd2 : (c == 2) ? 2'd3 : 2'd0;
            div_val   = (c == 1) ? 16'd1 : (c == 2) ? 16'd0 : 16'd9;
            sync_clr  = (c == 3);
            step();
            exp_t[0] = 1'b0;
            exp_t[1] = 1'b0;
            exp_t[2] = (c >= 4);
            exp_t[3] = (c >= 4) && (c != 8);
            chk("d_tick", c, 32'(tick), 32'(exp_t));
            chk("d_busy", c, 32'(busy),
                (c == 1) ? 32'h4 : (c == 2) ? 32'hc : (c == 10) ? 32'h1 : 32'h0);
        end
        rst       = 1'b1;
        div_valid = 1'b0;
        sync_clr  = 1'b0;
        en        = 4'b1111;
        step();
        chk("d_rst_tick", 11, 32'(tick), 32'h0);
        chk("d_rst_busy", 11, 32'(busy), 32'h0);
        rst = 1'b0;
        for (int c = 1; c <= 21; c++) begin
            step();
            chk("d_post_tick", c, 32'(tick), (c == 20) ? 32'hf : 32'h0);
            chk("d_post_busy", c, 32'(busy), 32'h0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
